// File: rtl/rng_clt_normal.sv
// Approximate standard-normal generator: sums N_UNIF successive 24-bit LFSR
// uniforms, subtracts N_UNIF/2 and presents the signed Q8.24 result via valid/ready.
//
// state | meaning
// ACCUM | consuming one uniform per en cycle, building the sum
// HOLD  | sample presented on rand_q8_24, waiting for out_ready
module rng_clt_normal #(
    parameter int unsigned N_UNIF       = 12,
    parameter logic [23:0] DEFAULT_SEED = 24'h000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        seed_load,
    input  logic [23:0] seed,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] rand_q8_24
);

    localparam int          CNT_W  = $clog2(N_UNIF + 1);
    localparam int          ACC_W  = 24 + CNT_W;
    localparam logic [31:0] OFFSET = 32'(N_UNIF) << 23;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    logic [23:0]        lfsr_q;
    logic [23:0]        lfsr_d;
    logic [23:0]        seed_safe;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q;
    logic [31:0]        rand_q;
    logic [31:0]        rand_d;
    logic               last_unif;

    // x^24 + x^23 + x^22 + x^17 + 1, Fibonacci form
    assign lfsr_d    = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
    assign seed_safe = (seed == 24'h000000) ? 24'h000001 : seed;
    assign last_unif = (cnt_q == CNT_W'(N_UNIF - 1));
    // Modulo-2^32 subtraction yields the same low 32 bits as the 33-bit form.
    assign rand_d    = 32'(acc_q) + 32'(lfsr_q) - OFFSET;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            lfsr_q  <= DEFAULT_SEED;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            rand_q  <= 32'h0;
        end else if (seed_load) begin
            state_q <= ACCUM;
            lfsr_q  <= seed_safe;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (en) begin
                        lfsr_q <= lfsr_d;
                        if (last_unif) begin
                            rand_q  <= rand_d;
                            valid_q <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            acc_q <= acc_q + ACC_W'(lfsr_q);
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign rand_q8_24 = rand_q;

endmodule

// File: tb/tb_rng_clt_normal.sv
// Bench for rng_clt_normal: N_UNIF=12 and N_UNIF=2 instances share stimulus;
// every accepted sample is compared against a sum-of-uniforms reference.
module tb_rng_clt_normal;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [23:0] seed = 24'h0;
    logic        out_ready = 1'b0;
    logic        v12, v2;
    logic [31:0] r12, r2;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acc12 = 0;
    int          n_acc2 = 0;
    bit          mon_on = 1'b0;
    logic [23:0] m12 = 24'h000001;
    logic [23:0] m2 = 24'h000001;

    always #5 clk = ~clk;

    rng_clt_normal dut12 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
        .out_ready(out_ready), .out_valid(v12), .rand_q8_24(r12)
    );

    rng_clt_normal #(.N_UNIF(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
        .out_ready(out_ready), .out_valid(v2), .rand_q8_24(r2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    endfunction

    // Sum n uniforms starting at s, centre by n/2, advance s past them.
    function automatic logic [31:0] next_sample(input int n, inout logic [23:0] s);
        longint     sum = 0;
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            sum += longint'(s);
            s = lfsr_next(s);
        end
        d = 64'(sum - (longint'(n) << 23));
        return d[31:0];
    endfunction

    always @(negedge clk) begin
        if (mon_on && !reset && !seed_load && out_ready) begin
            if (v2) begin
                chk("smp_n2", r2, next_sample(2, m2));
                n_acc2++;
            end
            if (v12) begin
                chk("smp_n12", r12, next_sample(12, m12));
                n_acc12++;
            end
        end
    end

    task automatic do_load(input logic [23:0] v);
        @(posedge clk); #1;
        seed_load = 1'b1;
        seed = v;
        m2 = (v == 24'h0) ? 24'h000001 : v;
        m12 = m2;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    initial begin
        int          a2, a12;
        bit          seen;
        logic [23:0] rs;

        #1 reset = 1'b1;
        #1;
        chk("rst_v12", 32'(v12), 32'd0);
        chk("rst_r12", r12, 32'h0);
        chk("rst_v2", 32'(v2), 32'd0);
        chk("rst_r2", r2, 32'h0);
        chk("rst_lfsr", 32'(dut12.lfsr_q), 32'h000001);
        #6 reset = 1'b0;

        // LFSR tap checks
        do_load(24'h800000);
        en = 1'b1; @(posedge clk); #1; en = 1'b0;
        chk("tap_800000", 32'(dut12.lfsr_q), 32'h000001);
        do_load(24'h810000);
        en = 1'b1; @(posedge clk); #1; en = 1'b0;
        chk("tap_810000", 32'(dut12.lfsr_q), 32'h020000);

        // Latency and first samples from seed 1
        mon_on = 1'b1;
        en = 1'b1; out_ready = 1'b1;
        do_load(24'h000001);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 1)  chk("lat2_early", 32'(v2), 32'd0);
            if (k == 2)  begin chk("lat2_v", 32'(v2), 32'd1); chk("n2_s0", r2, 32'hFF000003); end
            if (k == 3)  chk("n2_gap", 32'(v2), 32'd0);
            if (k == 4)  chk("n2_gap2", 32'(v2), 32'd0);
            if (k == 5)  begin chk("n2_v1", 32'(v2), 32'd1); chk("n2_s1", r2, 32'hFF00000C); end
            if (k == 11) chk("lat12_early", 32'(v12), 32'd0);
            if (k == 12) begin chk("lat12_v", 32'(v12), 32'd1); chk("n12_s0", r12, 32'hFA000FFF); end
        end

        // Zero seed behaves as seed 1
        do_load(24'h000000);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 2)  chk("zero_n2", r2, 32'hFF000003);
            if (k == 12) chk("zero_n12", r12, 32'hFA000FFF);
        end

        // Backpressure
        out_ready = 1'b0;
        do_load(24'h000001);
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(v2), 32'd1);
            chk("bp_data", r2, 32'hFF000003);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept", 32'(v2), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("bp_next_v", 32'(v2), 32'd1);
        chk("bp_next", r2, 32'hFF00000C);

        // Random en/ready timing from a random seed
        rs = 24'($urandom);
        do_load(rs);
        a2 = n_acc2; a12 = n_acc12;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            en = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end
        chk("rand_prog2", 32'(n_acc2 - a2 >= 20), 32'd1);
        chk("rand_prog12", 32'(n_acc12 - a12 >= 5), 32'd1);

        // seed_load beats a simultaneous handshake
        en = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk); #1;
            if (v2) seen = 1'b1;
        end
        chk("prio_wait", 32'(seen), 32'd1);
        seed_load = 1'b1;
        seed = 24'hABCDEF;
        m2 = 24'hABCDEF; m12 = 24'hABCDEF;
        @(posedge clk); #1;
        seed_load = 1'b0;
        chk("prio_v", 32'(v2), 32'd0);
        a2 = n_acc2;
        repeat (14) begin @(posedge clk); #1; end
        chk("prio_seq", 32'(n_acc2 - a2 >= 3), 32'd1);

        // Asynchronous reset mid-ACCUM
        @(posedge clk); #3;
        reset = 1'b1;
        m2 = 24'h000001; m12 = 24'h000001;
        #1;
        chk("arst_v2", 32'(v2), 32'd0);
        chk("arst_r2", r2, 32'h0);
        chk("arst_v12", 32'(v12), 32'd0);
        chk("arst_r12", r12, 32'h0);
        #3 reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 2)  chk("arst_n2", r2, 32'hFF000003);
            if (k == 12) chk("arst_n12", r12, 32'hFA000FFF);
        end

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
